// File: rtl/pong_pkg.sv
// Shared constants for the pong game-flow controller: state and winner
// encodings, default point delay and key-field positions.
package pong_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SERVE = 3'd1;
  localparam state_t ST_PLAY  = 3'd2;
  localparam state_t ST_PAUSE = 3'd3;
  localparam state_t ST_POINT = 3'd4;
  localparam state_t ST_OVER  = 3'd5;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  localparam int WAIT_FRAMES_DEFAULT = 120;

  localparam int KEY_L_HI = 3;
  localparam int KEY_L_LO = 2;
  localparam int KEY_R_HI = 1;
  localparam int KEY_R_LO = 0;

endpackage

// File: rtl/pong_game_ctrl_frame_timer.sv
// Frame-count down timer: loads a fixed value, counts frame ticks to zero
// and flags expiry while it reads zero.
module frame_timer #(
  parameter int W        = 7,
  parameter int LOAD_VAL = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  input  logic hold,
  output logic expired
);

  logic [W-1:0] cnt_q;

  // A tick coinciding with the load is dropped so the full delay is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(LOAD_VAL);
    end else if (tick && !hold && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Two-player pong game-flow controller: game state, scores, ball budget,
// serve side, rally count and inter-point delays.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int MODE        = 0,
  parameter int NUM_BALLS   = 3,
  parameter int WIN_SCORE   = 11,
  parameter int WAIT_FRAMES = WAIT_FRAMES_DEFAULT,
  parameter int SCORE_W     = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [3:0]         keys,
  input  logic               pause_key,
  input  logic               hit,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic [2:0]         state,
  output logic               gra_still,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [3:0]         balls_left,
  output logic               serve_dir,
  output logic [1:0]         winner,
  output logic [7:0]         rally
);

  localparam int                 TW         = $clog2(WAIT_FRAMES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_SC     = SCORE_W'(WIN_SCORE);
  localparam logic [3:0]         BALLS_INIT = (MODE == 0) ? 4'(NUM_BALLS) : 4'd0;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [3:0]         balls_q, balls_d;
  logic               serve_q, serve_d;
  logic [1:0]         winner_q, winner_d;
  logic [7:0]         rally_q, rally_d;
  logic               gra_still_q;
  logic               key_prev_q, pause_prev_q;

  logic key_any, press_ev, pause_ev, timer_load, timer_exp, game_done;

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [7:0] sat_rally(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign key_any  = (|keys[KEY_L_HI:KEY_L_LO]) | (|keys[KEY_R_HI:KEY_R_LO]);
  assign press_ev = key_any & ~key_prev_q;
  assign pause_ev = pause_key & ~pause_prev_q;

  assign game_done = (MODE == 0) ? (balls_q == 4'd0)
                                 : ((score_l_q >= WIN_SC) || (score_r_q >= WIN_SC));

  frame_timer #(.W(TW), .LOAD_VAL(WAIT_FRAMES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .tick    (frame_tick),
    .hold    (state_q == ST_PAUSE),
    .expired (timer_exp)
  );

  always_comb begin
    state_d    = state_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    balls_d    = balls_q;
    serve_d    = serve_q;
    winner_d   = winner_q;
    rally_d    = rally_q;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE:  if (press_ev) state_d = ST_SERVE;
      ST_SERVE: begin
        if (press_ev) begin
          state_d = ST_PLAY;
          if (MODE == 0) balls_d = balls_q - 4'd1;
        end
      end
      ST_PLAY: begin
        // Any miss ends the rally; a double miss is a void point.
        if (miss_l || miss_r) begin
          if (miss_l && !miss_r) begin
            score_r_d = sat_score(score_r_q);
            serve_d   = 1'b0;
          end else if (miss_r && !miss_l) begin
            score_l_d = sat_score(score_l_q);
            serve_d   = 1'b1;
          end
          rally_d    = '0;
          timer_load = 1'b1;
          state_d    = ST_POINT;
        end else begin
          if (hit) rally_d = sat_rally(rally_q);
          if (pause_ev) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: if (pause_ev) state_d = ST_PLAY;
      ST_POINT: begin
        if (timer_exp) begin
          if (game_done) begin
            state_d    = ST_OVER;
            timer_load = 1'b1;
            winner_d   = (score_l_q > score_r_q) ? WIN_LEFT :
                         (score_r_q > score_l_q) ? WIN_RIGHT : WIN_DRAW;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      ST_OVER:  if (timer_exp) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Idle shows a fresh game; applied on entry as well as while resident.
    if (state_d == ST_IDLE) begin
      score_l_d = '0;
      score_r_d = '0;
      balls_d   = BALLS_INIT;
      winner_d  = WIN_NONE;
      serve_d   = 1'b1;
      rally_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      score_l_q    <= '0;
      score_r_q    <= '0;
      balls_q      <= BALLS_INIT;
      serve_q      <= 1'b1;
      winner_q     <= WIN_NONE;
      rally_q      <= '0;
      gra_still_q  <= 1'b1;
      key_prev_q   <= 1'b0;
      pause_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      balls_q      <= balls_d;
      serve_q      <= serve_d;
      winner_q     <= winner_d;
      rally_q      <= rally_d;
      gra_still_q  <= (state_d != ST_PLAY);
      key_prev_q   <= key_any;
      pause_prev_q <= pause_key;
    end
  end

  assign state      = state_q;
  assign gra_still  = gra_still_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign balls_left = balls_q;
  assign serve_dir  = serve_q;
  assign winner     = winner_q;
  assign rally      = rally_q;

endmodule
